// File: rtl/motion_stream_sequencer_if.sv
// Stream-side bundle of motion_stream_sequencer: source FIFO heads, pipeline
// input writes and pipeline output monitoring.
interface motion_stream_sequencer_if;
  logic [23:0] bg_dout;
  logic        bg_empty;
  logic        bg_rd_en;
  logic [23:0] fr_dout;
  logic        fr_empty;
  logic        fr_rd_en;
  logic        A_full;
  logic        B_full;
  logic        C_full;
  logic        background_wr_en;
  logic [23:0] background_din;
  logic        frame_wr_en;
  logic [23:0] frame_din;
  logic        out_empty;
  logic        out_rd_en;

  modport master (
    input  bg_dout, bg_empty, fr_dout, fr_empty,
    input  A_full, B_full, C_full, out_empty, out_rd_en,
    output bg_rd_en, fr_rd_en, background_wr_en, background_din,
    output frame_wr_en, frame_din
  );

  modport slave (
    output bg_dout, bg_empty, fr_dout, fr_empty,
    output A_full, B_full, C_full, out_empty, out_rd_en,
    input  bg_rd_en, fr_rd_en, background_wr_en, background_din,
    input  frame_wr_en, frame_din
  );
endinterface

// File: rtl/motion_stream_sequencer.sv
// Streams one background/frame image pair into motion_detect_top, alternating
// bursts of BURST pixels, and pulses done once every output pixel is popped.
module motion_stream_sequencer #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int BURST  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  motion_stream_sequencer_if.master  bus
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C     = CW'(TOTAL - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BG    = 3'd1,
    FR    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   bg_cnt, fr_cnt, out_cnt;
  logic [CW-1:0]   fr_cnt_inc;
  logic [BW-1:0]   burst_cnt;
  logic            bg_xfer, fr_xfer, burst_end, clear, pop;

  // Transfers are combinational: the source pop and pipeline write happen in
  // the same cycle, gated only by state and the two-sided flow control.
  assign bg_xfer = (state == BG) && !bus.bg_empty && !bus.A_full;
  assign fr_xfer = (state == FR) && !bus.fr_empty && !bus.B_full && !bus.C_full;

  assign bus.bg_rd_en         = bg_xfer;
  assign bus.background_wr_en = bg_xfer;
  assign bus.background_din   = bus.bg_dout;
  assign bus.fr_rd_en         = fr_xfer;
  assign bus.frame_wr_en      = fr_xfer;
  assign bus.frame_din        = bus.fr_dout;

  assign fr_cnt_inc = fr_cnt + CW'(1);

  // A burst also closes early on the last pixel of an image.
  assign burst_end = (bg_xfer && (burst_cnt == BURST_LAST || bg_cnt == LAST_C)) ||
                     (fr_xfer && (burst_cnt == BURST_LAST || fr_cnt == LAST_C));

  assign busy = (state == BG) || (state == FR) || (state == DRAIN);
  assign done = (state == DONE);
  assign pop  = busy && bus.out_rd_en && !bus.out_empty;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BG;
          clear     = 1'b1;
        end
      end
      BG: begin
        if (burst_end) state_nxt = (fr_cnt < TOTAL_C) ? FR : DRAIN;
      end
      FR: begin
        if (burst_end) begin
          if (bg_cnt < TOTAL_C)          state_nxt = BG;
          else if (fr_cnt_inc < TOTAL_C) state_nxt = FR;
          else                           state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt == TOTAL_C) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bg_cnt    <= '0;
      fr_cnt    <= '0;
      out_cnt   <= '0;
      burst_cnt <= '0;
    end else if (clear) begin
      bg_cnt    <= '0;
      fr_cnt    <= '0;
      out_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      if (bg_xfer) bg_cnt <= bg_cnt + CW'(1);
      if (fr_xfer) fr_cnt <= fr_cnt_inc;
      if (burst_end)                burst_cnt <= '0;
      else if (bg_xfer || fr_xfer)  burst_cnt <= burst_cnt + BW'(1);
      if (pop && out_cnt != TOTAL_C) out_cnt <= out_cnt + CW'(1);
    end
  end

  a_exclusive_xfer : assert property (
    @(posedge clock) disable iff (!reset) !(bus.bg_rd_en && bus.fr_rd_en));

endmodule

// File: tb/tb_motion_stream_sequencer.sv
// Directed bench for motion_stream_sequencer with a 4x2 image and bursts of 3.
module tb_motion_stream_sequencer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int B = 3;
  localparam logic [15:0] EXP_BG = 16'h31C7;
  localparam logic [15:0] EXP_FR = 16'hCE38;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  int   total = 0;
  int   bad   = 0;

  motion_stream_sequencer_if bus ();

  motion_stream_sequencer #(.WIDTH(W), .HEIGHT(H), .BURST(B)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_job(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
  endtask

  // Records 16 cycles of writes from a fresh BG state; start pulses at pulse_at.
  task automatic run_job(input int pulse_at, input string tag);
    logic [15:0] got_bg = '0;
    logic [15:0] got_fr = '0;
    logic        pair_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      start = (i == pulse_at);
      #1;
      got_bg[i] = bus.bg_rd_en;
      got_fr[i] = bus.fr_rd_en;
      if (bus.bg_rd_en !== bus.background_wr_en || bus.fr_rd_en !== bus.frame_wr_en)
        pair_ok = 1'b0;
      tick();
    end
    start = 1'b0;
    check({tag, "_bg_seq"}, got_bg, EXP_BG);
    check({tag, "_fr_seq"}, got_fr, EXP_FR);
    check({tag, "_rd_wr_pair"}, pair_ok, 1);
    #1;
    check({tag, "_drain_busy"}, busy, 1);
    check({tag, "_drain_idle"}, {bus.bg_rd_en, bus.fr_rd_en}, 0);
  endtask

  // Eight pops with gap cycles between; gaps offer rd_en against an empty FIFO.
  task automatic drain_job(input int gap, input string tag);
    for (int p = 0; p < 8; p++) begin
      for (int g = 0; g < gap; g++) begin
        bus.out_rd_en = 1'b1;
        bus.out_empty = 1'b1;
        tick();
      end
      bus.out_rd_en = 1'b1;
      bus.out_empty = 1'b0;
      tick();
      bus.out_rd_en = 1'b0;
      bus.out_empty = 1'b1;
      if (p == 6) check({tag, "_not_done_at_7"}, {busy, done}, 2'b10);
    end
    check({tag, "_t1"}, {busy, done}, 2'b10);
    tick();
    check({tag, "_t2_done"}, {busy, done}, 2'b01);
    tick();
    check({tag, "_t3"}, {busy, done}, 2'b00);
    tick();
    check({tag, "_t4"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus.bg_dout   = 24'hABCDEF;
    bus.fr_dout   = 24'h123456;
    bus.bg_empty  = 1'b0;
    bus.fr_empty  = 1'b0;
    bus.A_full    = 1'b0;
    bus.B_full    = 1'b0;
    bus.C_full    = 1'b0;
    bus.out_empty = 1'b1;
    bus.out_rd_en = 1'b0;
    #12;
    check("reset_outputs", {busy, done, bus.bg_rd_en, bus.fr_rd_en,
                            bus.background_wr_en, bus.frame_wr_en}, 0);
    reset = 1'b1;
    tick();
    check("idle_outputs", {busy, done, bus.bg_rd_en, bus.fr_rd_en}, 0);

    // Test 1: uninterrupted sequence, then test 4 drain with spread pops.
    start_job("job1");
    #1;
    check("bg_din", bus.background_din, 24'hABCDEF);
    check("fr_din", bus.frame_din, 24'h123456);
    run_job(-1, "job1");
    drain_job(2, "drain1");

    // Test 2: A_full stall mid BG burst.
    start_job("job2");
    #1;
    check("job2_bg0", bus.bg_rd_en, 1);
    tick();
    bus.A_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("afull_stall", {bus.bg_rd_en, bus.background_wr_en, bus.fr_rd_en}, 0);
      tick();
    end
    bus.A_full = 1'b0;
    #1;
    check("afull_resume1", {bus.bg_rd_en, bus.fr_rd_en}, 2'b10);
    tick();
    check("afull_resume2", {bus.bg_rd_en, bus.fr_rd_en}, 2'b10);
    tick();
    check("afull_to_fr", {bus.bg_rd_en, bus.fr_rd_en}, 2'b01);

    // Test 3: either frame path full blocks the frame write.
    bus.B_full = 1'b1;
    #1;
    check("bfull_block", {bus.fr_rd_en, bus.frame_wr_en, bus.bg_rd_en}, 0);
    tick();
    bus.B_full = 1'b0;
    bus.C_full = 1'b1;
    #1;
    check("cfull_block", {bus.fr_rd_en, bus.frame_wr_en, bus.bg_rd_en}, 0);
    tick();
    bus.C_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fr_burst", {bus.bg_rd_en, bus.fr_rd_en}, 2'b01);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bg_burst2", {bus.bg_rd_en, bus.fr_rd_en}, 2'b10);
      tick();
    end
    tick();

    // Test 5: asynchronous reset mid FR burst.
    check("mid_fr", bus.fr_rd_en, 1);
    reset = 1'b0;
    #1;
    check("reset_async", {busy, done, bus.bg_rd_en, bus.fr_rd_en,
                          bus.background_wr_en, bus.frame_wr_en}, 0);
    #2;
    reset = 1'b1;
    tick();
    check("post_reset_idle", {busy, bus.bg_rd_en, bus.fr_rd_en}, 0);

    // Test 6: restart from zero with a start pulse while busy.
    start_job("job3");
    run_job(4, "job3");
    drain_job(0, "drain3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
